// File: rtl/cu_seq_if.sv
// Fetch and I/O handshake bundle between the sequencer (master) and its
// instruction memory / output sink (slave).
interface cu_seq_if #(
    parameter int ADDRW  = 16,
    parameter int INSTRW = 32
);
    logic              mem_req;
    logic [ADDRW-1:0]  mem_addr;
    logic              mem_ready;
    logic [INSTRW-1:0] mem_rdata;
    logic              io_req;
    logic              io_ready;

    modport master (
        output mem_req, mem_addr, io_req,
        input  mem_ready, mem_rdata, io_ready
    );
    modport slave (
        input  mem_req, mem_addr, io_req,
        output mem_ready, mem_rdata, io_ready
    );
endinterface

// File: rtl/cu_seq.sv
// Parametrised von Neumann instruction sequencer: owns ip, ir and the cycle
// state, and emits one-cycle decode/execute/write-back strobes.
module cu_seq #(
    parameter int ADDRW    = 16,
    parameter int INSTRW   = 32,
    parameter int IP_STEP  = 4,
    parameter int RESET_IP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    cu_seq_if.master          bus,
    output logic [INSTRW-1:0] ir,
    output logic              dec_en,
    output logic              exe_en,
    output logic              wb_en,
    input  logic              op_halt,
    input  logic [7:0]        halt_code,
    input  logic              op_jmp,
    input  logic              jmp_cond,
    input  logic [ADDRW-1:0]  jmp_off,
    input  logic              zf,
    input  logic              op_io,
    input  logic              data_busy,
    output logic [ADDRW-1:0]  ip,
    output logic [2:0]        state,
    output logic              halted,
    output logic [7:0]        exit_code
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_LOAD      = 3'd2,
        S_EXECUTE   = 3'd3,
        S_IO_WAIT   = 3'd4,
        S_INCREMENT = 3'd5,
        S_HALTED    = 3'd6
    } state_e;

    localparam logic [ADDRW-1:0] STEP   = ADDRW'(IP_STEP);
    localparam logic [ADDRW-1:0] IP_RST = ADDRW'(RESET_IP);

    state_e            state_q, state_d;
    logic [ADDRW-1:0]  ip_q, ip_d;
    logic [INSTRW-1:0] ir_q, ir_d;
    logic [7:0]        exit_code_q, exit_code_d;
    logic              jmp_taken;
    logic [ADDRW-1:0]  ip_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            ip_q        <= IP_RST;
            ir_q        <= '0;
            exit_code_q <= 8'hff;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            ir_q        <= ir_d;
            exit_code_q <= exit_code_d;
        end
    end

    // Offset is in instructions; the low ADDRW bits of the product are the
    // same whether jmp_off is treated as signed or unsigned.
    assign jmp_taken = op_jmp && (!jmp_cond || zf);
    assign ip_next   = jmp_taken ? ip_q + jmp_off * STEP : ip_q + STEP;

    always_comb begin
        state_d     = state_q;
        ip_d        = ip_q;
        ir_d        = ir_q;
        exit_code_d = exit_code_q;
        if (en) begin
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_d    = bus.mem_rdata;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: state_d = S_LOAD;
                S_LOAD: begin
                    if (op_halt) begin
                        exit_code_d = halt_code;
                        state_d     = S_HALTED;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (!data_busy) state_d = op_io ? S_IO_WAIT : S_INCREMENT;
                end
                S_IO_WAIT: begin
                    if (bus.io_ready) state_d = S_INCREMENT;
                end
                S_INCREMENT: begin
                    ip_d    = ip_next;
                    state_d = S_FETCH;
                end
                S_HALTED: state_d = S_HALTED;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    // Requests and strobes are pure Moore decodes, gated by en so a frozen
    // sequencer drives nothing and re-issues the same request on resume.
    assign bus.mem_req  = en && (state_q == S_FETCH);
    assign bus.mem_addr = ip_q;
    assign bus.io_req   = en && (state_q == S_IO_WAIT);
    assign dec_en       = en && (state_q == S_DECODE);
    assign exe_en       = en && (state_q == S_EXECUTE);
    assign wb_en        = en && (state_q == S_INCREMENT);

    assign ir        = ir_q;
    assign ip        = ip_q;
    assign state     = state_q;
    assign halted    = (state_q == S_HALTED);
    assign exit_code = exit_code_q;
endmodule

// File: tb/tb_cu_seq.sv
// Randomised scoreboard bench for cu_seq: an instruction-level timeline model
// queues per-cycle expectations, and a negedge monitor pops and compares them.
module tb_cu_seq;
  localparam int AW = 8;
  localparam int IW = 32;
  localparam logic [2:0] FE = 3'd0, DE = 3'd1, LO = 3'd2, EX = 3'd3,
                         IO = 3'd4, IN = 3'd5, HA = 3'd6;

  logic clk = 1'b0;
  logic rst_n, en;
  always #5 clk = ~clk;

  cu_seq_if #(.ADDRW(AW), .INSTRW(IW)) bus_if ();

  logic [IW-1:0] ir;
  logic          dec_en, exe_en, wb_en, halted;
  logic          op_halt, op_jmp, jmp_cond, zf, op_io, data_busy;
  logic [7:0]    halt_code, exit_code;
  logic [AW-1:0] jmp_off, ip;
  logic [2:0]    state;

  cu_seq #(.ADDRW(AW), .INSTRW(IW), .IP_STEP(4), .RESET_IP(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus_if),
    .ir(ir), .dec_en(dec_en), .exe_en(exe_en), .wb_en(wb_en),
    .op_halt(op_halt), .halt_code(halt_code), .op_jmp(op_jmp),
    .jmp_cond(jmp_cond), .jmp_off(jmp_off), .zf(zf), .op_io(op_io),
    .data_busy(data_busy), .ip(ip), .state(state), .halted(halted),
    .exit_code(exit_code)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic          mreq;
    logic [AW-1:0] maddr;
    logic          dec, exe, wb, ioreq;
    logic [AW-1:0] ipv;
    logic [IW-1:0] irv;
    logic          hlt;
    logic [7:0]    xc;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   n_cmp = 0, n_bad = 0, n_cyc = 0;

  // Architectural reference state
  int            m_ip;
  logic [IW-1:0] m_ir;
  logic          m_hlt;
  logic [7:0]    m_xc;

  task automatic expect_cycle(input logic [2:0] st, input logic act, input logic [IW-1:0] irv);
    obs_t o;
    o.st = st;
    o.mreq = act && st == FE;  o.maddr = AW'(m_ip);
    o.dec = act && st == DE;   o.exe = act && st == EX;
    o.wb = act && st == IN;    o.ioreq = act && st == IO;
    o.ipv = AW'(m_ip);         o.irv = irv;
    o.hlt = m_hlt;             o.xc = m_xc;
    exp_q.push_back(o);
  endtask

  always @(negedge clk) begin
    n_cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a.st = state;     mon_a.mreq = bus_if.mem_req; mon_a.maddr = bus_if.mem_addr;
      mon_a.dec = dec_en;   mon_a.exe = exe_en;          mon_a.wb = wb_en;
      mon_a.ioreq = bus_if.io_req; mon_a.ipv = ip;       mon_a.irv = ir;
      mon_a.hlt = halted;   mon_a.xc = exit_code;
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL cycle%0d got st=%0d req=%b addr=%h dec/exe/wb/io=%b%b%b%b ip=%h ir=%h hlt=%b xc=%h want st=%0d req=%b addr=%h dec/exe/wb/io=%b%b%b%b ip=%h ir=%h hlt=%b xc=%h",
                 n_cyc, mon_a.st, mon_a.mreq, mon_a.maddr, mon_a.dec, mon_a.exe, mon_a.wb, mon_a.ioreq,
                 mon_a.ipv, mon_a.irv, mon_a.hlt, mon_a.xc, mon_e.st, mon_e.mreq, mon_e.maddr,
                 mon_e.dec, mon_e.exe, mon_e.wb, mon_e.ioreq, mon_e.ipv, mon_e.irv, mon_e.hlt, mon_e.xc);
      end
    end
  end

  // One instruction: the enabled-cycle timeline is built from the stall counts,
  // en-low gaps are slotted anywhere before the final enabled cycle.
  task automatic run_instr(input int mw, input int busy, input int io, input int iow,
                           input logic jmp, input logic cond, input logic z, input logic [7:0] off,
                           input logic [31:0] gapv_in, input int rgaps,
                           input logic halt, input logic [7:0] code, input int nhold);
    logic [2:0]    ph[$];
    logic [31:0]   gapv;
    logic [IW-1:0] word;
    logic [2:0]    p;
    logic          g, taken;
    int            base, total, k, exe0, io_last, so, nip;
    word = $urandom;
    gapv = gapv_in;
    exe0 = 0;
    io_last = -1;
    for (int i = 0; i <= mw; i++) ph.push_back(FE);
    ph.push_back(DE);
    ph.push_back(LO);
    if (!halt) begin
      exe0 = ph.size();
      for (int i = 0; i <= busy; i++) ph.push_back(EX);
      if (io != 0) for (int i = 0; i <= iow; i++) ph.push_back(IO);
      io_last = ph.size() - 1;
      ph.push_back(IN);
    end
    base = ph.size();
    total = base + rgaps;
    while ($countones(gapv) < rgaps) gapv[$urandom_range(0, total - 2)] = 1'b1;
    total = base + $countones(gapv);
    k = 0;
    for (int c = 0; c < total; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus_if.mem_rdata = word;
        op_halt = halt;  halt_code = code;
        op_jmp = jmp;    jmp_cond = cond;  zf = z;  jmp_off = off;
        op_io = (io != 0);
      end
      g = gapv[c];
      p = ph[k];
      en = !g;
      bus_if.mem_ready = (!g && p == FE) ? (k == mw)      : 1'($urandom);
      bus_if.io_ready  = (!g && p == IO) ? (k == io_last) : 1'($urandom);
      data_busy        = (!g && p == EX) ? (k < exe0 + busy) : 1'($urandom);
      expect_cycle(p, !g, (k > mw) ? word : m_ir);
      if (!g) k++;
    end
    m_ir = word;
    if (halt) begin
      m_hlt = 1'b1;
      m_xc = code;
      for (int i = 0; i < nhold; i++) begin
        @(posedge clk); #1;
        en = 1'($urandom);
        bus_if.mem_ready = 1'($urandom);
        bus_if.io_ready = 1'($urandom);
        expect_cycle(HA, en, m_ir);
      end
    end else begin
      so = int'(off);
      if (so > 127) so -= 256;
      taken = jmp && (!cond || z);
      nip = m_ip + (taken ? 4 * so : 4);
      m_ip = ((nip % 256) + 256) % 256;
    end
  endtask

  task automatic rand_instr();
    run_instr($urandom_range(0, 3), $urandom_range(0, 2), int'($urandom_range(0, 3) == 0),
              $urandom_range(0, 4), ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
              8'($urandom), 32'h0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
              1'b0, 8'h00, 0);
  endtask

  task automatic reset_release();
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b0;
    m_ip = 0;  m_ir = '0;  m_hlt = 1'b0;  m_xc = 8'hff;
    expect_cycle(FE, 1'b0, m_ir);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    en = 1'b0;
    expect_cycle(m_hlt ? HA : FE, 1'b0, m_ir);
    reset_release();
  endtask

  initial begin
    rst_n = 1'b0;  en = 1'b1;
    bus_if.mem_ready = 1'b0;  bus_if.mem_rdata = '0;  bus_if.io_ready = 1'b0;
    op_halt = 1'b0;  halt_code = 8'h00;  op_jmp = 1'b0;  jmp_cond = 1'b0;
    jmp_off = '0;  zf = 1'b0;  op_io = 1'b0;  data_busy = 1'b0;
    repeat (2) @(posedge clk);
    reset_release();
    // Three back-to-back sequential instructions: ip 0 -> 4 -> 8 -> 12
    repeat (3) run_instr(0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 0);
    // Three fetch wait states: ip 12 -> 16
    run_instr(3, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 0);
    // Backward jump to fc, then sequential wrap to 00 and on to 04
    run_instr(0, 0, 0, 0, 1, 0, 0, 8'hfb, 32'h0, 0, 0, 8'h00, 0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 0);
    // jmp_off = -2 at 04 -> fc
    run_instr(0, 0, 0, 0, 1, 0, 0, 8'hfe, 32'h0, 0, 0, 8'h00, 0);
    // Conditional jump: zf=0 falls through, zf=1 with offset 3 adds 12
    run_instr(0, 0, 0, 0, 1, 1, 0, 8'h03, 32'h0, 0, 0, 8'h00, 0);
    run_instr(0, 1, 0, 0, 1, 1, 1, 8'h03, 32'h0, 0, 0, 8'h00, 0);
    // I/O wait with en dropped for two cycles inside IO_WAIT
    run_instr(0, 0, 1, 3, 0, 0, 0, 8'h00, 32'h0000_0060, 0, 0, 8'h00, 0);
    repeat (150) rand_instr();
    // Halt with code 2a, then reset while halted
    run_instr(1, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 1, 1, 8'h2a, 4);
    reset_pulse();
    repeat (5) rand_instr();
    run_instr(0, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 2, 1, 8'($urandom), 3);
    reset_pulse();
    rand_instr();
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
